// File: rtl/pisatel_v_banki_if.sv
// CPU write ports and bank write strobes of the banked-memory write front end.
// master = CPU/driver side, slave = pisatel_v_banki.
interface pisatel_v_banki_if #(
    parameter int NUM_BANKS          = 3,
    parameter int SIZE_BANKI         = 32,
    parameter int NUM_WR_PORTS       = 4,
    parameter int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
    parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS)
);
    logic [NUM_WR_PORTS-1:0][SHIRINA_VSEH_BANOK-1:0] wa;
    logic [NUM_WR_PORTS-1:0][31:0]                   wd;
    logic [NUM_WR_PORTS-1:0]                         wreq_cpu;
    logic [NUM_WR_PORTS-1:0]                         wrdy_cpu;
    logic [NUM_WR_PORTS-1:0]                         wdone_cpu;
    logic [NUM_WR_PORTS-1:0]                         werr_cpu;
    logic [NUM_BANKS-1:0]                            we_banki;
    logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]         wadr_banki;
    logic [NUM_BANKS-1:0][31:0]                      wdata_banki;

    modport master (
        output wa, wd, wreq_cpu,
        input  wrdy_cpu, wdone_cpu, werr_cpu, we_banki, wadr_banki, wdata_banki
    );

    modport slave (
        input  wa, wd, wreq_cpu,
        output wrdy_cpu, wdone_cpu, werr_cpu, we_banki, wadr_banki, wdata_banki
    );
endinterface

// File: rtl/pisatel_v_banki.sv
// Write front end of the banked memory: one-entry buffer per CPU port, round-robin per bank.
// Optional macro PISATEL_WRDY_BYPASS_EN lets a buffer freed this cycle accept a new write at once.
module pisatel_v_banki #(
    parameter int NUM_BANKS          = 3,
    parameter int SIZE_BANKI         = 32,
    parameter int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
    parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS),
    parameter int NUM_WR_PORTS       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pisatel_v_banki_if.slave     bus
);
    localparam int PW    = $clog2(NUM_WR_PORTS);
    localparam int AW    = SHIRINA_VSEH_BANOK;
    localparam int OW    = SHIRINA_BANKI;
    localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int TOTAL = NUM_BANKS * SIZE_BANKI;

    logic [NUM_WR_PORTS-1:0]          buf_vld;
    logic [NUM_WR_PORTS-1:0][AW-1:0]  buf_adr;
    logic [NUM_WR_PORTS-1:0][31:0]    buf_dat;
    logic [NUM_BANKS-1:0][PW-1:0]     rr_ptr;

    logic [NUM_WR_PORTS-1:0]          in_range;
    logic [NUM_WR_PORTS-1:0]          retire_err;
    logic [NUM_WR_PORTS-1:0]          gnt;
    logic [NUM_WR_PORTS-1:0]          accept;
    logic [NUM_WR_PORTS-1:0][BW-1:0]  buf_bank;
    logic [NUM_WR_PORTS-1:0][OW-1:0]  buf_off;
    logic [NUM_BANKS-1:0]             bank_gnt;
    logic [NUM_BANKS-1:0][PW-1:0]     bank_sel;

    logic [NUM_WR_PORTS-1:0]          wdone_q;
    logic [NUM_WR_PORTS-1:0]          werr_q;
    logic [NUM_BANKS-1:0]             we_q;
    logic [NUM_BANKS-1:0][OW-1:0]     wadr_q;
    logic [NUM_BANKS-1:0][31:0]       wdata_q;

    always_comb begin
        in_range   = '0;
        retire_err = '0;
        buf_bank   = '0;
        buf_off    = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            in_range[p]   = 32'(buf_adr[p]) < 32'(TOTAL);
            buf_bank[p]   = BW'(32'(buf_adr[p]) / 32'(SIZE_BANKI));
            buf_off[p]    = OW'(32'(buf_adr[p]) % 32'(SIZE_BANKI));
            retire_err[p] = buf_vld[p] & ~in_range[p];
        end
    end

    // Search starts just after the last winner, so the previous winner ends up last.
    always_comb begin
        logic [PW-1:0] idx;
        gnt      = '0;
        bank_gnt = '0;
        bank_sel = '0;
        idx      = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 1; k <= NUM_WR_PORTS; k++) begin
                idx = PW'((int'(rr_ptr[b]) + k) % NUM_WR_PORTS);
                if (!bank_gnt[b] && buf_vld[idx] && in_range[idx] &&
                    int'(buf_bank[idx]) == b) begin
                    bank_gnt[b] = 1'b1;
                    bank_sel[b] = idx;
                    gnt[idx]    = 1'b1;
                end
            end
        end
    end

`ifdef PISATEL_WRDY_BYPASS_EN
    assign bus.wrdy_cpu = ~buf_vld | gnt | retire_err;
`else
    assign bus.wrdy_cpu = ~buf_vld;
`endif

    assign accept = bus.wreq_cpu & bus.wrdy_cpu;

    // A new capture wins over the release of the same entry (bypass refill).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld <= '0;
            buf_adr <= '0;
            buf_dat <= '0;
        end else begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (accept[p]) begin
                    buf_vld[p] <= 1'b1;
                    buf_adr[p] <= bus.wa[p];
                    buf_dat[p] <= bus.wd[p];
                end else if (gnt[p] || retire_err[p]) begin
                    buf_vld[p] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdone_q <= '0;
            werr_q  <= '0;
            we_q    <= '0;
            wadr_q  <= '0;
            wdata_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr[b] <= PW'(NUM_WR_PORTS - 1);
            end
        end else begin
            wdone_q <= gnt | retire_err;
            werr_q  <= retire_err;
            we_q    <= bank_gnt;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_gnt[b]) begin
                    wadr_q[b]  <= buf_off[bank_sel[b]];
                    wdata_q[b] <= buf_dat[bank_sel[b]];
                    rr_ptr[b]  <= bank_sel[b];
                end
            end
        end
    end

    assign bus.wdone_cpu   = wdone_q;
    assign bus.werr_cpu    = werr_q;
    assign bus.we_banki    = we_q;
    assign bus.wadr_banki  = wadr_q;
    assign bus.wdata_banki = wdata_q;
endmodule

// File: tb/tb_pisatel_v_banki.sv
// Scoreboard bench for pisatel_v_banki: directed writes push expected bank writes and
// retirements; a negedge monitor pops and compares them, including the cycle they appear.
module tb_pisatel_v_banki;
    localparam int NB = 3;
    localparam int SZ = 32;
    localparam int NP = 4;

    typedef struct { logic [6:0] adr; logic [31:0] dat; } wr_item_t;
    typedef struct { int cyc; logic [4:0] off; logic [31:0] dat; } bank_exp_t;
    typedef struct { int cyc; logic err; } done_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   t0  = 0;
    int   total = 0;
    int   bad   = 0;

    wr_item_t  pend[NP][$];
    bank_exp_t exp_bank[NB][$];
    done_exp_t exp_done[NP][$];

    pisatel_v_banki_if #(.NUM_BANKS(NB), .SIZE_BANKI(SZ), .NUM_WR_PORTS(NP)) bus ();

    pisatel_v_banki #(.NUM_BANKS(NB), .SIZE_BANKI(SZ), .NUM_WR_PORTS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bank_exp_t be;
        done_exp_t de;
        for (int b = 0; b < NB; b++) begin
            if (bus.we_banki[b]) begin
                total++;
                if (exp_bank[b].size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_bank_write bank=%0d got off=%0d data=%h cyc=%0d required no write",
                             b, bus.wadr_banki[b], bus.wdata_banki[b], cyc);
                end else begin
                    be = exp_bank[b].pop_front();
                    if (bus.wadr_banki[b] !== be.off || bus.wdata_banki[b] !== be.dat || cyc != be.cyc) begin
                        bad++;
                        $display("[TB] FAIL bank_write bank=%0d got off=%0d data=%h cyc=%0d required off=%0d data=%h cyc=%0d",
                                 b, bus.wadr_banki[b], bus.wdata_banki[b], cyc, be.off, be.dat, be.cyc);
                    end
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (bus.wdone_cpu[p]) begin
                total++;
                if (exp_done[p].size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_wdone port=%0d got err=%0b cyc=%0d required no wdone",
                             p, bus.werr_cpu[p], cyc);
                end else begin
                    de = exp_done[p].pop_front();
                    if (bus.werr_cpu[p] !== de.err || cyc != de.cyc) begin
                        bad++;
                        $display("[TB] FAIL wdone port=%0d got err=%0b cyc=%0d required err=%0b cyc=%0d",
                                 p, bus.werr_cpu[p], cyc, de.err, de.cyc);
                    end
                end
            end else if (bus.werr_cpu[p]) begin
                total++;
                bad++;
                $display("[TB] FAIL werr_without_wdone port=%0d got werr=1 required 0 cyc=%0d", p, cyc);
            end
        end
    end

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h required=%0h", name, got, want);
        end
    endtask

    // Queue one CPU write and its hand-computed outcome, rel cycles after t0.
    task automatic expect_write(input int port, input logic [6:0] adr, input logic [31:0] dat,
                                input int bank, input logic [4:0] off, input logic err, input int rel);
        wr_item_t  it;
        bank_exp_t be;
        done_exp_t de;
        it.adr = adr;
        it.dat = dat;
        pend[port].push_back(it);
        de.cyc = t0 + rel;
        de.err = err;
        exp_done[port].push_back(de);
        if (!err) begin
            be.cyc = t0 + rel;
            be.off = off;
            be.dat = dat;
            exp_bank[bank].push_back(be);
        end
    endtask

    task automatic apply_stimulus(input int n);
        logic [NP-1:0] fire;
        for (int c = 0; c < n; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (pend[p].size() > 0) begin
                    bus.wreq_cpu[p] = 1'b1;
                    bus.wa[p]       = pend[p][0].adr;
                    bus.wd[p]       = pend[p][0].dat;
                end else begin
                    bus.wreq_cpu[p] = 1'b0;
                end
            end
            #1;
            fire = bus.wreq_cpu & bus.wrdy_cpu;
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (fire[p] && pend[p].size() > 0) void'(pend[p].pop_front());
            end
        end
        bus.wreq_cpu = '0;
    endtask

    initial begin
        bus.wreq_cpu = '1;
        bus.wa       = '0;
        bus.wd       = '0;
        repeat (3) @(negedge clk);
        check_output("rst_wrdy",  128'(bus.wrdy_cpu),    128'hF);
        check_output("rst_we",    128'(bus.we_banki),    128'h0);
        check_output("rst_wdone", 128'(bus.wdone_cpu),   128'h0);
        check_output("rst_werr",  128'(bus.werr_cpu),    128'h0);
        check_output("rst_wadr",  128'(bus.wadr_banki),  128'h0);
        check_output("rst_wdata", 128'(bus.wdata_banki), 128'h0);
        bus.wreq_cpu = '0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_output("idle_wrdy", 128'(bus.wrdy_cpu), 128'hF);

        $display("[TB] contention on bank 0");
        t0 = cyc;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < NP; p++) begin
                expect_write(p, 7'(p * 4 + i), 32'hC000_0000 | 32'(p << 8) | 32'(i),
                             0, 5'(p * 4 + i), 1'b0, 2 + i * 4 + p);
            end
        end
        apply_stimulus(14);

        $display("[TB] single write");
        t0 = cyc;
        expect_write(1, 7'd40, 32'hDEAD_BEEF, 1, 5'd8, 1'b0, 2);
        apply_stimulus(5);
        check_output("hold_we",    128'(bus.we_banki),       128'h0);
        check_output("hold_wadr1", 128'(bus.wadr_banki[1]),  128'd8);
        check_output("hold_wdat1", 128'(bus.wdata_banki[1]), 128'hDEAD_BEEF);

        $display("[TB] parallel banks");
        t0 = cyc;
        expect_write(0, 7'd5,  32'h1111_0005, 0, 5'd5, 1'b0, 2);
        expect_write(2, 7'd70, 32'h2222_0046, 2, 5'd6, 1'b0, 2);
        apply_stimulus(5);

        $display("[TB] address range edges");
        t0 = cyc;
        expect_write(3, 7'd100, 32'h4444_0100, 0, 5'd0,  1'b1, 2);
        expect_write(2, 7'd96,  32'h4444_0096, 0, 5'd0,  1'b1, 2);
        expect_write(1, 7'd95,  32'h3333_0095, 2, 5'd31, 1'b0, 2);
        apply_stimulus(5);

        $display("[TB] stream on port 0");
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
`ifdef PISATEL_WRDY_BYPASS_EN
            expect_write(0, 7'(64 + i), 32'hB000_0000 + 32'(i), 2, 5'(i), 1'b0, 2 + i);
`else
            expect_write(0, 7'(64 + i), 32'hB000_0000 + 32'(i), 2, 5'(i), 1'b0, 2 + 2 * i);
`endif
        end
        apply_stimulus(16);

        $display("[TB] reset during stream");
        t0 = cyc;
        expect_write(0, 7'd80, 32'hE000_0000, 2, 5'd16, 1'b0, 2);
`ifdef PISATEL_WRDY_BYPASS_EN
        expect_write(0, 7'd81, 32'hE000_0001, 2, 5'd17, 1'b0, 3);
`else
        pend[0].push_back('{adr: 7'd81, dat: 32'hE000_0001});
`endif
        pend[0].push_back('{adr: 7'd82, dat: 32'hE000_0002});
        pend[0].push_back('{adr: 7'd83, dat: 32'hE000_0003});
        apply_stimulus(3);
        #2;
        rst = 1'b0;
        #1;
        check_output("midrst_we",    128'(bus.we_banki),  128'h0);
        check_output("midrst_wdone", 128'(bus.wdone_cpu), 128'h0);
        check_output("midrst_wrdy",  128'(bus.wrdy_cpu),  128'hF);
        for (int p = 0; p < NP; p++) pend[p].delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        for (int b = 0; b < NB; b++) check_output($sformatf("missing_bank%0d", b), 128'(exp_bank[b].size()), 128'd0);
        for (int p = 0; p < NP; p++) check_output($sformatf("missing_done%0d", p), 128'(exp_done[p].size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
